// File: rtl/fixedpt_iterative_divider_pkg.sv
// Shared types and constants for the fixed-point iterative divider.
package fixedpt_div_pkg;

    // Controller states: waiting for operands, iterating, presenting result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default geometry, Q16.16 in a 32-bit word.
    localparam int N_DEF = 32;
    localparam int D_DEF = 16;

    // Step counter must hold the value n+d.
    localparam int CNT_W = $clog2(N_DEF + D_DEF + 1);

    // Step counter width for an arbitrary geometry.
    function automatic int cnt_w(input int nn, input int dd);
        return $clog2(nn + dd + 1);
    endfunction

    // Largest positive two's-complement value of an nn-bit word.
    function automatic logic [63:0] max_pos(input int nn);
        return (64'd1 << (nn - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of an nn-bit word (bit pattern).
    function automatic logic [63:0] min_neg(input int nn);
        return 64'd1 << (nn - 1);
    endfunction

endpackage

// File: rtl/fixedpt_iterative_divider_if.sv
// Operand/result stream bundle for the divider, val/rdy on both sides.
interface fixedpt_iterative_divider_if #(
    parameter int n = 32
);
    logic                recv_val;
    logic                recv_rdy;
    logic signed [n-1:0] a;
    logic signed [n-1:0] b;
    logic                send_val;
    logic                send_rdy;
    logic signed [n-1:0] c;
    logic                ovf;
    logic                dbz;

    // Producer/consumer side that drives operands and accepts results.
    modport master (
        output recv_val, a, b, send_rdy,
        input  recv_rdy, send_val, c, ovf, dbz
    );

    // Divider side.
    modport slave (
        input  recv_val, a, b, send_rdy,
        output recv_rdy, send_val, c, ovf, dbz
    );
endinterface

// File: rtl/fixedpt_iterative_divider_ctrl.sv
// Divider sequencing: FSM, step counter, handshake outputs and write-enables.
module fixedpt_div_ctrl
    import fixedpt_div_pkg::*;
#(
    parameter int n = 32,
    parameter int d = 16
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   recv_val,
    input  logic   send_rdy,
    input  logic   b_zero,
    output state_t state,
    output logic   recv_rdy,
    output logic   send_val,
    output logic   load,
    output logic   step
);

    localparam int            CW       = cnt_w(n, d);
    localparam logic [CW-1:0] CNT_INIT = CW'(n + d);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Operand capture happens on the accepting edge; a step on every CALC edge.
    assign load = recv_val && recv_rdy && (state == IDLE);
    assign step = (state == CALC);

    // FSM with registered handshake outputs; the zero-divisor path spends one
    // cycle in DONE before raising send_val so its result lands one cycle after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (recv_val && recv_rdy) begin
                        recv_rdy <= 1'b0;
                        if (b_zero) begin
                            state <= DONE;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                CALC: begin
                    if (cnt == CNT_ONE) begin
                        state    <= DONE;
                        send_val <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    if (!send_val) begin
                        send_val <= 1'b1;
                    end else if (send_rdy) begin
                        send_val <= 1'b0;
                        recv_rdy <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    recv_rdy <= 1'b1;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fixedpt_iterative_divider.sv
// Signed Q(n-d).d restoring divider, one quotient bit per cycle, with
// saturation on overflow and a fixed response to a zero divisor.
module fixedpt_iterative_divider
    import fixedpt_div_pkg::*;
#(
    parameter int n = 32,
    parameter int d = 16
) (
    input logic                        clk,
    input logic                        reset,
    fixedpt_iterative_divider_if.slave bus
);

    localparam int             QW        = n + d;
    localparam logic [63:0]    MAX_POS_W = max_pos(n);
    localparam logic [63:0]    MIN_NEG_W = min_neg(n);
    localparam logic [n-1:0]   MAX_POS   = MAX_POS_W[n-1:0];
    localparam logic [n-1:0]   MIN_NEG   = MIN_NEG_W[n-1:0];

    state_t          state;
    logic            load;
    logic            step;
    logic            b_zero;

    logic [n-1:0]    bmag;
    logic [QW-1:0]   dvd;
    logic [n-1:0]    rem;
    logic [QW-1:0]   quo;
    logic            neg;
    logic            a_neg;
    logic            dbz_r;

    logic [n:0]      rem_sh;
    logic            ge;

    logic [n-1:0]    c_v;
    logic            ovf_v;
    logic            dbz_v;

    // Unsigned magnitude; the most negative value maps to 2^(n-1).
    function automatic logic [n-1:0] mag(input logic signed [n-1:0] v);
        logic [n-1:0] u;
        u = v;
        return u[n-1] ? ('0 - u) : u;
    endfunction

    // Signed result from the quotient magnitude, saturating on overflow.
    // Returns {ovf, c}.
    function automatic logic [n:0] saturate(input logic [QW-1:0] q, input logic negative);
        logic [n-1:0] lo;
        logic [n-1:0] lo_neg;
        lo     = q[n-1:0];
        lo_neg = '0 - lo;
        if (!negative) begin
            if (q > QW'(MAX_POS)) return {1'b1, MAX_POS};
            return {1'b0, lo};
        end
        if (q > QW'(MIN_NEG)) return {1'b1, MIN_NEG};
        return {1'b0, lo_neg};
    endfunction

    assign b_zero = (bus.b == '0);

    fixedpt_div_ctrl #(
        .n (n),
        .d (d)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .recv_val (bus.recv_val),
        .send_rdy (bus.send_rdy),
        .b_zero   (b_zero),
        .state    (state),
        .recv_rdy (bus.recv_rdy),
        .send_val (bus.send_val),
        .load     (load),
        .step     (step)
    );

    // Restoring step: append the next dividend bit, subtract if it fits.
    // The remainder stays below |b| <= 2^(n-1), so n bits hold it after the step.
    always_comb begin
        rem_sh = {rem, dvd[QW-1]};
        ge     = (rem_sh >= {1'b0, bmag});
    end

    // Operand capture on accept, then one quotient bit per CALC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bmag  <= '0;
            dvd   <= '0;
            rem   <= '0;
            quo   <= '0;
            neg   <= 1'b0;
            a_neg <= 1'b0;
            dbz_r <= 1'b0;
        end else if (load) begin
            bmag  <= mag(bus.b);
            dvd   <= {mag(bus.a), {d{1'b0}}};
            rem   <= '0;
            quo   <= '0;
            neg   <= bus.a[n-1] ^ bus.b[n-1];
            a_neg <= bus.a[n-1];
            dbz_r <= b_zero;
        end else if (step) begin
            dvd <= dvd << 1;
            rem <= ge ? (rem_sh[n-1:0] - bmag) : rem_sh[n-1:0];
            quo <= {quo[QW-2:0], ge};
        end
    end

    // Result formation from the registers; outputs read zero outside DONE.
    always_comb begin
        c_v   = '0;
        ovf_v = 1'b0;
        dbz_v = 1'b0;
        if (state == DONE) begin
            if (dbz_r) begin
                c_v   = a_neg ? MIN_NEG : MAX_POS;
                dbz_v = 1'b1;
            end else begin
                {ovf_v, c_v} = saturate(quo, neg);
            end
        end
    end

    assign bus.c   = c_v;
    assign bus.ovf = ovf_v;
    assign bus.dbz = dbz_v;

endmodule
